queue_alloc_manage: RTL and testbench

Controller for the fragment-sorting queue RAM (32 queues × 16 entries of {last_frag_flag, bufid[8:0]}). It allocates a free queue id to each new packet and generates queue-RAM write addresses for that packet's fragments. It publishes the per-queue `queue_empty` vector consumed by the queue reader, and returns queues to the free pool when the reader reports the packet drained. It sits between the fragment classifier (write side) and `queue_read` (read side) in the last-node process.

---
 rtl/queue_alloc_manage_pkg.sv | 26 ++
 rtl/queue_alloc_manage_free_queue_encoder.sv | 29 ++
 rtl/queue_alloc_manage.sv | 187 ++++++++++++++++++
 tb/tb_queue_alloc_manage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_alloc_manage_pkg.sv
// ============================================================================
// queue_alloc_manage_pkg : shared geometry and queue-state encodings
// Revision : 1.0
// ============================================================================
`default_nettype none

package queue_alloc_manage_pkg;

  localparam int QUEUE_NUM   = 32;
  localparam int QUEUE_DEPTH = 16;
  localparam int QID_W       = 5;
  localparam int PTR_W       = 4;
  localparam int BUFID_W     = 9;
  localparam int ADDR_W      = QID_W + PTR_W;
  localparam int DATA_W      = BUFID_W + 1;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    Q_FREE    = 2'd0,
    Q_FILLING = 2'd1,
    Q_READY   = 2'd2
  } q_state_e;

endpackage

`default_nettype wire

// File: rtl/queue_alloc_manage_free_queue_encoder.sv
// ============================================================================
// free_queue_encoder : lowest-set-bit priority encoder over the FREE mask
// Revision : 1.0
// ============================================================================
`default_nettype none

module free_queue_encoder
  import queue_alloc_manage_pkg::*;
(
  input  logic [QUEUE_NUM-1:0] iv_mask,
  output logic                 o_found,
  output logic [QID_W-1:0]     ov_qid
);

  // Scan high to low so the lowest set bit is the final one written.
  always_comb begin
    o_found = 1'b0;
    ov_qid  = '0;
    for (int i = QUEUE_NUM - 1; i >= 0; i--) begin
      if (iv_mask[i]) begin
        o_found = 1'b1;
        ov_qid  = QID_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/queue_alloc_manage.sv
// ============================================================================
// queue_alloc_manage : queue id allocation, fragment write addressing and
// queue_empty publication. Optional statistics counters under FRAG_STAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module queue_alloc_manage
  import queue_alloc_manage_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alloc_req,
  output logic [QID_W-1:0]     ov_alloc_qid,
  output logic                 o_alloc_ack,
  output logic                 o_alloc_fail,
  input  logic                 i_frag_wr,
  input  logic [QID_W-1:0]     iv_frag_qid,
  input  logic [BUFID_W-1:0]   iv_frag_bufid,
  input  logic                 i_frag_last,
  output logic                 o_frag_err,
  output logic                 o_queue_ram_wr,
  output logic [ADDR_W-1:0]    ov_queue_ram_waddr,
  output logic [DATA_W-1:0]    ov_queue_ram_wdata,
  output logic [QUEUE_NUM-1:0] ov_queue_empty,
  input  logic [QID_W-1:0]     iv_queue_id_free,
  input  logic                 i_queue_id_free_wr,
  output logic [CNT_W-1:0]     ov_alloc_fail_cnt,
  output logic [CNT_W-1:0]     ov_frag_err_cnt
);

  q_state_e         state_q [QUEUE_NUM];
  q_state_e         state_d [QUEUE_NUM];
  logic [PTR_W-1:0] wptr_q  [QUEUE_NUM];
  logic [PTR_W-1:0] wptr_d  [QUEUE_NUM];

  logic               alloc_ack_q,  alloc_ack_d;
  logic               alloc_fail_q, alloc_fail_d;
  logic [QID_W-1:0]   alloc_qid_q,  alloc_qid_d;
  logic               ram_wr_q,     ram_wr_d;
  logic [ADDR_W-1:0]  ram_waddr_q,  ram_waddr_d;
  logic [DATA_W-1:0]  ram_wdata_q,  ram_wdata_d;
  logic               frag_err_q,   frag_err_d;

  logic [QUEUE_NUM-1:0] free_mask;
  logic [QUEUE_NUM-1:0] empty_vec;
  logic                 enc_found;
  logic [QID_W-1:0]     enc_qid;
  logic                 free_hit;
  logic                 frag_ok;

  always_comb begin
    free_mask = '0;
    empty_vec = '0;
    for (int q = 0; q < QUEUE_NUM; q++) begin
      free_mask[q] = (state_q[q] == Q_FREE);
      empty_vec[q] = (state_q[q] != Q_READY);
    end
  end

  free_queue_encoder u_free_queue_encoder (
    .iv_mask (free_mask),
    .o_found (enc_found),
    .ov_qid  (enc_qid)
  );

  // Alloc only touches FREE queues, free only READY ones, fragments only
  // FILLING ones, so the three updates below never target the same entry.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    alloc_ack_d  = 1'b0;
    alloc_fail_d = 1'b0;
    alloc_qid_d  = '0;
    ram_wr_d     = 1'b0;
    ram_waddr_d  = '0;
    ram_wdata_d  = '0;
    frag_err_d   = 1'b0;

    if (i_alloc_req) begin
      if (enc_found) begin
        state_d[enc_qid] = Q_FILLING;
        wptr_d[enc_qid]  = '0;
        alloc_ack_d      = 1'b1;
        alloc_qid_d      = enc_qid;
      end else begin
        alloc_fail_d = 1'b1;
      end
    end

    free_hit = i_queue_id_free_wr && (state_q[iv_queue_id_free] == Q_READY);
    if (free_hit) begin
      state_d[iv_queue_id_free] = Q_FREE;
      wptr_d[iv_queue_id_free]  = '0;
    end

    // Entry 15 is held back for the last fragment; a colliding free wins.
    frag_ok = (state_q[iv_frag_qid] == Q_FILLING)
           && !(free_hit && (iv_queue_id_free == iv_frag_qid))
           && ((wptr_q[iv_frag_qid] != PTR_W'(QUEUE_DEPTH - 1)) || i_frag_last);

    if (i_frag_wr) begin
      if (frag_ok) begin
        ram_wr_d               = 1'b1;
        ram_waddr_d            = {iv_frag_qid, wptr_q[iv_frag_qid]};
        ram_wdata_d            = {i_frag_last, iv_frag_bufid};
        wptr_d[iv_frag_qid]    = wptr_q[iv_frag_qid] + 1'b1;
        if (i_frag_last) begin
          state_d[iv_frag_qid] = Q_READY;
        end
      end else begin
        frag_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int q = 0; q < QUEUE_NUM; q++) begin
        state_q[q] <= Q_FREE;
        wptr_q[q]  <= '0;
      end
      alloc_ack_q  <= 1'b0;
      alloc_fail_q <= 1'b0;
      alloc_qid_q  <= '0;
      ram_wr_q     <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      frag_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      alloc_ack_q  <= alloc_ack_d;
      alloc_fail_q <= alloc_fail_d;
      alloc_qid_q  <= alloc_qid_d;
      ram_wr_q     <= ram_wr_d;
      ram_waddr_q  <= ram_waddr_d;
      ram_wdata_q  <= ram_wdata_d;
      frag_err_q   <= frag_err_d;
    end
  end

  assign o_alloc_ack        = alloc_ack_q;
  assign o_alloc_fail       = alloc_fail_q;
  assign ov_alloc_qid       = alloc_qid_q;
  assign o_queue_ram_wr     = ram_wr_q;
  assign ov_queue_ram_waddr = ram_waddr_q;
  assign ov_queue_ram_wdata = ram_wdata_q;
  assign o_frag_err         = frag_err_q;
  assign ov_queue_empty     = empty_vec;

`ifdef FRAG_STAT_EN
  logic [CNT_W-1:0] alloc_fail_cnt_q, alloc_fail_cnt_d;
  logic [CNT_W-1:0] frag_err_cnt_q,   frag_err_cnt_d;

  // Counters follow the registered pulses and saturate at all-ones.
  always_comb begin
    alloc_fail_cnt_d = alloc_fail_cnt_q;
    frag_err_cnt_d   = frag_err_cnt_q;
    if (alloc_fail_q && (alloc_fail_cnt_q != '1)) begin
      alloc_fail_cnt_d = alloc_fail_cnt_q + 1'b1;
    end
    if (frag_err_q && (frag_err_cnt_q != '1)) begin
      frag_err_cnt_d = frag_err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alloc_fail_cnt_q <= '0;
      frag_err_cnt_q   <= '0;
    end else begin
      alloc_fail_cnt_q <= alloc_fail_cnt_d;
      frag_err_cnt_q   <= frag_err_cnt_d;
    end
  end

  assign ov_alloc_fail_cnt = alloc_fail_cnt_q;
  assign ov_frag_err_cnt   = frag_err_cnt_q;
`else
  assign ov_alloc_fail_cnt = '0;
  assign ov_frag_err_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_queue_alloc_manage.sv
// ============================================================================
// tb_queue_alloc_manage : table-driven directed checks for queue_alloc_manage
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_queue_alloc_manage;

  logic        clk;
  logic        rst_n;
  logic        alloc_req;
  logic [4:0]  alloc_qid;
  logic        alloc_ack;
  logic        alloc_fail;
  logic        frag_wr;
  logic [4:0]  frag_qid;
  logic [8:0]  frag_bufid;
  logic        frag_last;
  logic        frag_err;
  logic        ram_wr;
  logic [8:0]  ram_waddr;
  logic [9:0]  ram_wdata;
  logic [31:0] queue_empty;
  logic [4:0]  free_qid;
  logic        free_wr;
  logic [15:0] fail_cnt;
  logic [15:0] err_cnt;

  int n_pass;
  int n_total;

  queue_alloc_manage dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_alloc_req        (alloc_req),
    .ov_alloc_qid       (alloc_qid),
    .o_alloc_ack        (alloc_ack),
    .o_alloc_fail       (alloc_fail),
    .i_frag_wr          (frag_wr),
    .iv_frag_qid        (frag_qid),
    .iv_frag_bufid      (frag_bufid),
    .i_frag_last        (frag_last),
    .o_frag_err         (frag_err),
    .o_queue_ram_wr     (ram_wr),
    .ov_queue_ram_waddr (ram_waddr),
    .ov_queue_ram_wdata (ram_wdata),
    .ov_queue_empty     (queue_empty),
    .iv_queue_id_free   (free_qid),
    .i_queue_id_free_wr (free_wr),
    .ov_alloc_fail_cnt  (fail_cnt),
    .ov_frag_err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alloc;
    logic        fwr;
    logic [4:0]  fq;
    logic [8:0]  fb;
    logic        fl;
    logic        frw;
    logic [4:0]  frq;
    logic        e_ack;
    logic        e_fail;
    logic [4:0]  e_qid;
    logic        e_wr;
    logic [8:0]  e_addr;
    logic [9:0]  e_data;
    logic        e_err;
    logic [31:0] e_empty;
  } vec_t;

  function automatic vec_t mk(
    logic alloc, logic fwr, logic [4:0] fq, logic [8:0] fb, logic fl,
    logic frw, logic [4:0] frq,
    logic e_ack, logic e_fail, logic [4:0] e_qid,
    logic e_wr, logic [8:0] e_addr, logic [9:0] e_data, logic e_err,
    logic [31:0] e_empty);
    vec_t v;
    v.alloc = alloc; v.fwr = fwr; v.fq = fq; v.fb = fb; v.fl = fl;
    v.frw = frw; v.frq = frq;
    v.e_ack = e_ack; v.e_fail = e_fail; v.e_qid = e_qid;
    v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data; v.e_err = e_err;
    v.e_empty = e_empty;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle_inputs();
    alloc_req  = 1'b0;
    frag_wr    = 1'b0;
    frag_qid   = '0;
    frag_bufid = '0;
    frag_last  = 1'b0;
    free_wr    = 1'b0;
    free_qid   = '0;
  endtask

  task automatic apply(input vec_t v, input string nm);
    alloc_req  = v.alloc;
    frag_wr    = v.fwr;
    frag_qid   = v.fq;
    frag_bufid = v.fb;
    frag_last  = v.fl;
    free_wr    = v.frw;
    free_qid   = v.frq;
    @(posedge clk);
    #1;
    chk({nm, ".ack"},   32'(alloc_ack),   32'(v.e_ack));
    chk({nm, ".fail"},  32'(alloc_fail),  32'(v.e_fail));
    chk({nm, ".qid"},   32'(alloc_qid),   32'(v.e_qid));
    chk({nm, ".wr"},    32'(ram_wr),      32'(v.e_wr));
    chk({nm, ".waddr"}, 32'(ram_waddr),   32'(v.e_addr));
    chk({nm, ".wdata"}, 32'(ram_wdata),   32'(v.e_data));
    chk({nm, ".err"},   32'(frag_err),    32'(v.e_err));
    chk({nm, ".empty"}, queue_empty,      v.e_empty);
    idle_inputs();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".ack"},   32'(alloc_ack),  32'h0);
    chk({nm, ".fail"},  32'(alloc_fail), 32'h0);
    chk({nm, ".qid"},   32'(alloc_qid),  32'h0);
    chk({nm, ".wr"},    32'(ram_wr),     32'h0);
    chk({nm, ".waddr"}, 32'(ram_waddr),  32'h0);
    chk({nm, ".wdata"}, 32'(ram_wdata),  32'h0);
    chk({nm, ".err"},   32'(frag_err),   32'h0);
    chk({nm, ".empty"}, queue_empty,     32'hFFFF_FFFF);
    chk({nm, ".fcnt"},  32'(fail_cnt),   32'h0);
    chk({nm, ".ecnt"},  32'(err_cnt),    32'h0);
  endtask

  localparam logic [31:0] E_ALL = 32'hFFFF_FFFF;
  localparam logic        X0 = 1'b0;
  localparam logic        X1 = 1'b1;

  vec_t tbl [15];
  int   exp_fail_cnt;
  int   exp_err_cnt;

  initial begin
    //            al  fwr fq     fb       fl  frw frq    ack fail qid    wr  addr     data       err empty
    tbl[0]  = mk(X1, X0, 5'd0, 9'h000, X0, X0, 5'd0,  X1, X0, 5'd0,  X0, 9'h000, 10'h000, X0, E_ALL);
    tbl[1]  = mk(X1, X0, 5'd0, 9'h000, X0, X0, 5'd0,  X1, X0, 5'd1,  X0, 9'h000, 10'h000, X0, E_ALL);
    tbl[2]  = mk(X1, X0, 5'd0, 9'h000, X0, X0, 5'd0,  X1, X0, 5'd2,  X0, 9'h000, 10'h000, X0, E_ALL);
    tbl[3]  = mk(X0, X1, 5'd0, 9'h010, X0, X0, 5'd0,  X0, X0, 5'd0,  X1, 9'h000, 10'h010, X0, E_ALL);
    tbl[4]  = mk(X0, X1, 5'd0, 9'h011, X1, X0, 5'd0,  X0, X0, 5'd0,  X1, 9'h001, 10'h211, X0, 32'hFFFF_FFFE);
    tbl[5]  = mk(X0, X0, 5'd0, 9'h000, X0, X1, 5'd0,  X0, X0, 5'd0,  X0, 9'h000, 10'h000, X0, E_ALL);
    tbl[6]  = mk(X1, X0, 5'd0, 9'h000, X0, X0, 5'd0,  X1, X0, 5'd0,  X0, 9'h000, 10'h000, X0, E_ALL);
    tbl[7]  = mk(X0, X1, 5'd7, 9'h0AB, X0, X0, 5'd0,  X0, X0, 5'd0,  X0, 9'h000, 10'h000, X1, E_ALL);
    tbl[8]  = mk(X0, X0, 5'd0, 9'h000, X0, X1, 5'd1,  X0, X0, 5'd0,  X0, 9'h000, 10'h000, X0, E_ALL);
    tbl[9]  = mk(X0, X1, 5'd1, 9'h1AB, X0, X0, 5'd0,  X0, X0, 5'd0,  X1, 9'h010, 10'h1AB, X0, E_ALL);
    tbl[10] = mk(X0, X1, 5'd2, 9'h0FF, X1, X0, 5'd0,  X0, X0, 5'd0,  X1, 9'h020, 10'h2FF, X0, 32'hFFFF_FFFB);
    tbl[11] = mk(X1, X1, 5'd1, 9'h005, X0, X1, 5'd2,  X1, X0, 5'd3,  X1, 9'h011, 10'h005, X0, E_ALL);
    tbl[12] = mk(X1, X0, 5'd0, 9'h000, X0, X0, 5'd0,  X1, X0, 5'd2,  X0, 9'h000, 10'h000, X0, E_ALL);
    tbl[13] = mk(X1, X0, 5'd0, 9'h000, X0, X0, 5'd0,  X1, X0, 5'd4,  X0, 9'h000, 10'h000, X0, E_ALL);
    tbl[14] = mk(X1, X0, 5'd0, 9'h000, X0, X0, 5'd0,  X1, X0, 5'd5,  X0, 9'h000, 10'h000, X0, E_ALL);

    n_pass = 0;
    n_total = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // q5: 15 non-last fragments fill entries 0..14, the 16th is refused
    for (int i = 0; i < 15; i++) begin
      apply(mk(X0, X1, 5'd5, 9'(i + 8'h40), X0, X0, 5'd0,
               X0, X0, 5'd0, X1, 9'(9'h050 + i), 10'(i + 8'h40), X0, E_ALL),
            $sformatf("q5_frag%0d", i));
    end
    apply(mk(X0, X1, 5'd5, 9'h0AA, X0, X0, 5'd0,
             X0, X0, 5'd0, X0, 9'h000, 10'h000, X1, E_ALL), "q5_16th_nonlast");
    apply(mk(X0, X1, 5'd5, 9'h1FF, X1, X0, 5'd0,
             X0, X0, 5'd0, X1, 9'h05F, 10'h3FF, X0, 32'hFFFF_FFDF), "q5_last");
    apply(mk(X0, X1, 5'd5, 9'h001, X1, X0, 5'd0,
             X0, X0, 5'd0, X0, 9'h000, 10'h000, X1, 32'hFFFF_FFDF), "q5_ready_frag");

    for (int i = 0; i < 26; i++) begin
      apply(mk(X1, X0, 5'd0, 9'h000, X0, X0, 5'd0,
               X1, X0, 5'(6 + i), X0, 9'h000, 10'h000, X0, 32'hFFFF_FFDF),
            $sformatf("fill%0d", 6 + i));
    end
    apply(mk(X1, X0, 5'd0, 9'h000, X0, X0, 5'd0,
             X0, X1, 5'd0, X0, 9'h000, 10'h000, X0, 32'hFFFF_FFDF), "full_fail");

    // Freed queue is not visible to an alloc in the same cycle
    apply(mk(X0, X1, 5'd4, 9'h033, X1, X0, 5'd0,
             X0, X0, 5'd0, X1, 9'h040, 10'h233, X0, 32'hFFFF_FFCF), "q4_last");
    apply(mk(X1, X0, 5'd0, 9'h000, X0, X1, 5'd4,
             X0, X1, 5'd0, X0, 9'h000, 10'h000, X0, 32'hFFFF_FFDF), "free4_alloc_same");
    apply(mk(X1, X0, 5'd0, 9'h000, X0, X0, 5'd0,
             X1, X0, 5'd4, X0, 9'h000, 10'h000, X0, 32'hFFFF_FFDF), "alloc_retry4");

    @(posedge clk);
    #1;
`ifdef FRAG_STAT_EN
    exp_fail_cnt = 2;
    exp_err_cnt  = 3;
`else
    exp_fail_cnt = 0;
    exp_err_cnt  = 0;
`endif
    chk("alloc_fail_cnt", 32'(fail_cnt), 32'(exp_fail_cnt));
    chk("frag_err_cnt",   32'(err_cnt),  32'(exp_err_cnt));

    // Asynchronous reset in the middle of a fragment write
    frag_wr    = 1'b1;
    frag_qid   = 5'd6;
    frag_bufid = 9'h077;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    idle_inputs();
    @(posedge clk);
    #1;
    chk("midreset_hold.wr", 32'(ram_wr), 32'h0);
    rst_n = 1'b1;
    apply(mk(X1, X0, 5'd0, 9'h000, X0, X0, 5'd0,
             X1, X0, 5'd0, X0, 9'h000, 10'h000, X0, E_ALL), "post_reset_alloc");
    apply(mk(X0, X1, 5'd5, 9'h012, X1, X0, 5'd0,
             X0, X0, 5'd0, X0, 9'h000, 10'h000, X1, E_ALL), "post_reset_q5_free");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
